// File: rtl/load_store_unit_pkg.sv
// load_store_unit_pkg: shared widths, funct3 and fault codes, FSM states and command legality check
package load_store_unit_pkg;
  localparam int XLEN = 32;
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;
  localparam logic [2:0] FC_NONE           = 3'd0;
  localparam logic [2:0] FC_LOAD_MISALIGN  = 3'd1;
  localparam logic [2:0] FC_STORE_MISALIGN = 3'd2;
  localparam logic [2:0] FC_ILLEGAL        = 3'd3;
  localparam logic [2:0] FC_TIMEOUT        = 3'd4;
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_REL, S_DONE, S_FAULT} lsu_state_e;
  // Illegal funct3 outranks misalignment; FC_NONE means the command may go to memory.
  function automatic logic [2:0] cmd_fault(input logic is_store, input logic [2:0] f3, input logic [1:0] a);
    logic legal, mis;
    legal = is_store ? (f3 inside {SB, SH, SW}) : (f3 inside {LB, LH, LW, LBU, LHU});
    mis = (f3[1:0] == 2'b01 && a[0]) || (f3[1:0] == 2'b10 && a != 2'b00);
    return !legal ? FC_ILLEGAL : !mis ? FC_NONE : is_store ? FC_STORE_MISALIGN : FC_LOAD_MISALIGN;
  endfunction
endpackage

// File: rtl/load_store_unit_load_extend.sv
// lsu_load_extend: sign/zero extends a right-aligned load field according to funct3
//   i_funct3 : RV32I load funct3
//   i_data   : raw memory field, right-aligned
//   o_data   : extended result (unknown funct3 passes data through)
module lsu_load_extend
  import load_store_unit_pkg::*;
(
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_data,
  output logic [XLEN-1:0] o_data
);
  always_comb
    o_data = i_funct3 == LB  ? {{(XLEN-8){i_data[7]}}, i_data[7:0]} :
             i_funct3 == LH  ? {{(XLEN-16){i_data[15]}}, i_data[15:0]} :
             i_funct3 == LBU ? {{(XLEN-8){1'b0}}, i_data[7:0]} :
             i_funct3 == LHU ? {{(XLEN-16){1'b0}}, i_data[15:0]} : i_data;
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: validates one load/store command and runs a four-phase req/ack handshake with data memory
//   i_clk, i_rst_n            : clock, async active-low reset
//   i_start/i_is_store/i_funct3/i_addr/i_wdata : core command, sampled only when idle
//   o_busy/o_done/o_rdata/o_fault/o_fault_cause : status back to the core
//   o_mem_req/o_mem_addr/o_mem_data/o_mem_funct3/o_mem_read_write : request to memory
//   i_mem_ack/i_mem_data      : memory acknowledge and right-aligned read data
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int TCNT_W  = 5
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_start,
  input  logic            i_is_store,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_addr,
  input  logic [XLEN-1:0] i_wdata,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_rdata,
  output logic            o_fault,
  output logic [2:0]      o_fault_cause,
  output logic            o_mem_req,
  output logic [XLEN-1:0] o_mem_addr,
  output logic [XLEN-1:0] o_mem_data,
  output logic [2:0]      o_mem_funct3,
  output logic            o_mem_read_write,
  input  logic            i_mem_ack,
  input  logic [XLEN-1:0] i_mem_data
);
  lsu_state_e state_q, state_d;
  logic [TCNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] addr_q, wdata_q, data_q, rdata_q, ext_data;
  logic [2:0] f3_q, cause_q, cmd_cause;
  logic rw_q, timeout;
  assign cmd_cause = cmd_fault(i_is_store, i_funct3, i_addr[1:0]);
  assign timeout = cnt_q == TCNT_W'(TIMEOUT - 1);
  lsu_load_extend u_ext (.i_funct3(f3_q), .i_data(data_q), .o_data(ext_data));
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = !i_start ? S_IDLE : cmd_cause == FC_NONE ? S_REQ : S_FAULT;
      S_REQ:   state_d = i_mem_ack ? S_REL : timeout ? S_FAULT : S_REQ;
      S_REL:   state_d = !i_mem_ack ? S_DONE : timeout ? S_FAULT : S_REL;
      default: state_d = S_IDLE;
    endcase
    // The counter restarts on every state change so each handshake phase gets its own budget.
    cnt_d = (state_d == state_q && (state_q == S_REQ || state_q == S_REL)) ? cnt_q + 1'b1 : '0;
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
      rw_q    <= 1'b0;
      cause_q <= FC_NONE;
      data_q  <= '0;
      rdata_q <= '0;
    end else begin
      if (state_q == S_IDLE && i_start) begin
        addr_q  <= i_addr;
        wdata_q <= i_wdata;
        f3_q    <= i_funct3;
        rw_q    <= !i_is_store;
        cause_q <= cmd_cause;
      end
      if (state_q != S_IDLE && state_d == S_FAULT) cause_q <= FC_TIMEOUT;
      if (state_q == S_REQ && i_mem_ack) data_q <= i_mem_data;
      if (state_q == S_REL && state_d == S_DONE && rw_q) rdata_q <= ext_data;
    end
  always_comb begin
    o_busy           = state_q != S_IDLE;
    o_mem_req        = state_q == S_REQ;
    o_done           = state_q == S_DONE;
    o_fault          = state_q == S_FAULT;
    o_fault_cause    = o_fault ? cause_q : FC_NONE;
    o_rdata          = rdata_q;
    o_mem_addr       = addr_q;
    o_mem_data       = wdata_q;
    o_mem_funct3     = f3_q;
    o_mem_read_write = rw_q;
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: randomized and directed checking of load_store_unit against a behavioural model
module tb_load_store_unit;
  localparam int TO = 16;
  logic clk = 0, rst_n = 0, start = 0, is_store = 0, ack = 0;
  logic [2:0] f3 = 0;
  logic [31:0] addr = 0, wdata = 0, mem_rdata = 0;
  logic busy, done, fault, mem_req, mem_rw;
  logic [2:0] cause, mem_f3;
  logic [31:0] rdata, mem_addr, mem_wdata;
  logic [31:0] mem [64];
  logic [31:0] exp_rdata = 0;
  int checks = 0, failures = 0, ack_mode = 0;

  load_store_unit #(.TIMEOUT(TO), .TCNT_W(5)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_is_store(is_store), .i_funct3(f3),
    .i_addr(addr), .i_wdata(wdata), .o_busy(busy), .o_done(done), .o_rdata(rdata),
    .o_fault(fault), .o_fault_cause(cause), .o_mem_req(mem_req), .o_mem_addr(mem_addr),
    .o_mem_data(mem_wdata), .o_mem_funct3(mem_f3), .o_mem_read_write(mem_rw),
    .i_mem_ack(ack), .i_mem_data(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Memory: mode 0 acks one cycle after req and releases with it, 1 never acks, 2 acks and sticks high.
  always @(negedge clk) begin : mem_model
    int sh;
    logic [31:0] mask;
    if (mem_req && !ack) begin
      sh = 8 * int'(mem_addr[1:0]);
      mask = mem_f3[1:0] == 2'b00 ? 32'hFF : mem_f3[1:0] == 2'b01 ? 32'hFFFF : 32'hFFFF_FFFF;
      if (mem_rw) mem_rdata = mem[mem_addr[7:2]] >> sh;
      else mem[mem_addr[7:2]] = (mem[mem_addr[7:2]] & ~(mask << sh)) | ((mem_wdata & mask) << sh);
    end
    ack = ack_mode == 0 ? mem_req : ack_mode == 1 ? 1'b0 : (ack | mem_req);
  end

  function automatic logic [2:0] exp_cause(input logic st, input logic [2:0] fn, input logic [31:0] a);
    bit legal;
    int bytes;
    legal = st ? (fn < 3) : (fn < 3 || fn == 4 || fn == 5);
    bytes = 1 << (fn % 4);
    if (!legal) return 3;
    if (a % bytes != 0) return st ? 3'd2 : 3'd1;
    return 0;
  endfunction

  function automatic logic [31:0] exp_ext(input logic [2:0] fn, input logic [31:0] field);
    int v;
    case (fn)
      3'd0: begin v = int'(field % 256); if (v >= 128) v -= 256; return v; end
      3'd1: begin v = int'(field % 65536); if (v >= 32768) v -= 65536; return v; end
      3'd4: return field % 256;
      3'd5: return field % 65536;
      default: return field;
    endcase
  endfunction

  task automatic txn(input logic st, input logic [2:0] fn, input logic [31:0] a, input logic [31:0] wd,
                     input int mode, input bit poke);
    logic [2:0] ec, got_cause;
    logic [31:0] field;
    bit got_done, got_fault;
    int n_end, reqs;
    ec = exp_cause(st, fn, a);
    if (ec == 0 && mode != 0) ec = 4;
    field = mem[a[7:2]] >> (8 * int'(a[1:0]));
    got_done = 0; got_fault = 0; got_cause = 0; n_end = 0; reqs = 0;
    ack_mode = mode;
    @(negedge clk);
    start = 1; is_store = st; f3 = fn; addr = a; wdata = wd;
    for (int n = 1; n <= 3 * TO + 8; n++) begin
      @(negedge clk);
      start = poke;
      if (poke) begin is_store = ~st; f3 = 3'b111; addr = a + 1; end
      if (mem_req) begin
        reqs++;
        check("mem_addr", mem_addr, a);
        check("mem_rw", {31'b0, mem_rw}, {31'b0, ~st});
      end
      if (!fault) check("cause_quiet", {29'b0, cause}, 0);
      if (done || fault) begin
        got_done = done; got_fault = fault; got_cause = cause; n_end = n;
        break;
      end
    end
    start = 0;
    ack_mode = 0;
    check("completion", {31'b0, got_done | got_fault}, 1);
    check("done", {31'b0, got_done}, {31'b0, ec == 0});
    check("fault", {31'b0, got_fault}, {31'b0, ec != 0});
    check("cause", {29'b0, got_cause}, {29'b0, ec});
    if (ec == 0) check("latency", n_end, 3);
    if (ec != 0 && ec != 4) check("no_req", reqs, 0);
    if (ec == 4) check("req_cycles", reqs, mode == 1 ? TO : 1);
    if (ec == 0 && !st) exp_rdata = exp_ext(fn, field);
    check("rdata", rdata, exp_rdata);
    @(negedge clk);
    check("idle_after", {31'b0, busy}, 0);
  endtask

  initial begin
    logic [31:0] d;
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_req", {31'b0, mem_req}, 0);
    check("rst_done", {31'b0, done}, 0);
    check("rst_fault", {31'b0, fault}, 0);
    check("rst_cause", {29'b0, cause}, 0);
    check("rst_rdata", rdata, 0);
    check("rst_mem_addr", mem_addr, 0);
    rst_n = 1;
    mem[4] = 32'h8000_00F0;
    txn(0, 3'b010, 32'h10, 0, 0, 0);
    check("lw_value", rdata, 32'h8000_00F0);
    mem[4] = 32'h0000_8000;
    txn(0, 3'b000, 32'h11, 0, 0, 0);
    check("lb_value", rdata, 32'hFFFF_FF80);
    txn(0, 3'b100, 32'h11, 0, 0, 0);
    check("lbu_value", rdata, 32'h0000_0080);
    mem[4] = 32'h8001_0000;
    txn(0, 3'b101, 32'h12, 0, 0, 0);
    check("lhu_value", rdata, 32'h0000_8001);
    txn(1, 3'b001, 32'h13, 0, 0, 0);
    txn(0, 3'b010, 32'h02, 0, 0, 0);
    txn(0, 3'b011, 32'h20, 0, 0, 0);
    txn(1, 3'b010, 32'h20, 32'hDEAD_BEEF, 1, 0);
    txn(0, 3'b010, 32'h24, 0, 2, 0);
    ack_mode = 1;
    @(negedge clk);
    start = 1; is_store = 0; f3 = 3'b010; addr = 32'h30;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    check("arst_req", {31'b0, mem_req}, 0);
    check("arst_busy", {31'b0, busy}, 0);
    check("arst_done", {31'b0, done}, 0);
    check("arst_rdata", rdata, 0);
    exp_rdata = 0;
    @(negedge clk);
    rst_n = 1;
    ack_mode = 0;
    txn(0, 3'b010, 32'h30, 0, 0, 0);
    d = $urandom;
    txn(1, 3'b010, 32'h40, d, 0, 1);
    txn(0, 3'b010, 32'h40, 0, 0, 1);
    check("b2b_rdata", rdata, d);
    for (int i = 0; i < 60; i++)
      txn(1'($urandom % 2), 3'($urandom % 8), $urandom % 256, $urandom,
          ($urandom % 8 == 0) ? 1 + int'($urandom % 2) : 0, 1'($urandom % 4 == 0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the data-memory request/ack interface; sits between the core's execute/memory stage and data_memory.
- Accepts one load or store command from the core, checks alignment and funct3, and runs a four-phase req/ack handshake with memory.
- Re-applies sign/zero extension to returned load data and reports completion or a fault to the core.

Parameters:
- TIMEOUT, 16, max cycles to wait in either handshake phase before a timeout fault (must be ≥2).
- TCNT_W, 5, width of the timeout counter; must hold TIMEOUT.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst_n  input  1  reset, asynchronous, active-low.
- i_start  input  1  core command strobe; sampled only in IDLE.
- i_is_store  input  1  1 = store, 0 = load.
- i_funct3  input  3  RV32I load/store funct3.
- i_addr  input  `XLEN  byte address.
- i_wdata  input  `XLEN  store data, right-aligned.
- o_busy  output  1  high in any state other than IDLE.
- o_done  output  1  one-cycle completion pulse.
- o_rdata  output  `XLEN  extended load result; valid with o_done on loads.
- o_fault  output  1  one-cycle fault pulse, mutually exclusive with o_done.
- o_fault_cause  output  3  0 none, 1 load misaligned, 2 store misaligned, 3 illegal funct3, 4 timeout.
- o_mem_req  output  1  memory request level.
- o_mem_addr  output  `XLEN  latched address.
- o_mem_data  output  `XLEN  latched store data, passed raw; memory places the byte lanes.
- o_mem_funct3  output  3  latched funct3.
- o_mem_read_write  output  1  1 = read (load), 0 = write (store).
- i_mem_ack  input  1  memory acknowledge.
- i_mem_data  input  `XLEN  memory read data; field is right-aligned.

Behaviour:
- Reset (async, any state):
  - State goes to IDLE.
  - All outputs are 0, including o_mem_req, o_done, o_fault, o_fault_cause, o_rdata and the o_mem_* buses.
  - An in-flight request is abandoned; o_mem_req drops immediately.
- IDLE:
  - On i_start, latch addr, wdata, funct3 and is_store into the o_mem_* registers.
  - Legal funct3: loads 000/001/010/100/101; stores 000/001/010. Anything else → FAULT with cause 3.
  - Alignment: halfword requires addr[0]=0; word requires addr[1:0]=0. Violation → FAULT with cause 1 (load) or 2 (store).
  - Illegal funct3 takes priority over misalignment.
  - A faulting command issues no memory request.
  - Otherwise → REQ.
  - i_start while busy is ignored, with no queueing.
- REQ:
  - o_mem_req=1; the timeout counter increments each cycle.
  - When i_mem_ack=1 is sampled: capture i_mem_data, then → REL.
  - If the counter reaches TIMEOUT first → FAULT with cause 4.
- REL:
  - o_mem_req=0; the counter is cleared on entry.
  - Wait for i_mem_ack=0, then → DONE.
  - Timeout here → FAULT with cause 4.
  - Ack already low on entry → DONE next cycle.
- DONE:
  - o_done=1 for exactly one cycle, then → IDLE.
- FAULT:
  - o_fault=1 for one cycle with o_fault_cause held; o_mem_req=0; then → IDLE.
  - o_fault_cause stays 0 outside FAULT.
- Load extension, from captured data d:
  - 000: sign-extend d[7:0].
  - 001: sign-extend d[15:0].
  - 010: d.
  - 100: zero-extend d[7:0].
  - 101: zero-extend d[15:0].
  - o_rdata holds until the next DONE or reset.
  - Stores leave o_rdata unchanged.
- Latency with ack returned one cycle after req: start → REQ(1) → REL(1) → DONE, so o_done occurs 3 cycles after i_start.
- The o_mem_* address/data/funct3/read_write outputs are stable from REQ entry through the end of REL.

Decomposition:
- Shared header.vh holds:
  - `XLEN.
  - funct3 constants: LB, LH, LW, LBU, LHU, SB, SH, SW.
  - fault cause codes FC_NONE..FC_TIMEOUT.
  - LSU state encodings.
- One natural sub-module, lsu_load_extend: combinational funct3 + data → extended result; reused by a future cache path.

Test Plan:
- LW at addr 0x10 with memory word 0x8000_00F0, ack after 1 cycle → req high 1 cycle; o_done on cycle 3; o_rdata=0x8000_00F0.
- LB at 0x11, memory returns 0x0000_0080 → o_rdata=0xFFFF_FF80. Same case as LBU → 0x0000_0080. LHU returning 0x0000_8001 → 0x0000_8001.
- SH at 0x13 → o_fault with cause 2, o_mem_req never asserts. LW at 0x02 → cause 1. funct3=011 on a load → cause 3.
- SW at 0x20 with data 0xDEADBEEF and ack held low → o_fault cause 4 after TIMEOUT cycles. Ack stuck high after release → cause 4 from REL.
- i_rst_n pulled low mid-REQ → o_mem_req, o_busy and o_done are 0 asynchronously. A new LW after reset completes normally.
- Back-to-back SW then LW to the same address, with i_start re-asserted during busy (ignored) → two done pulses, second o_rdata equals the stored value.
